lfsr_checker: RTL and testbench

LFSR_CHECKER -- requirements
Module: lfsr_checker

---
 rtl/lfsr_pkg.sv | 19 +
 rtl/lfsr_checker.sv | 99 +++++++++
 tb/tb_lfsr_checker.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/lfsr_pkg.sv
// Shared definitions for the 4-bit x^4+x^3+1 LFSR generator/checker pair.
package lfsr_pkg;

  localparam int unsigned LFSR_W = 4;

  typedef logic [LFSR_W-1:0] word_t;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  // Successor of q in the 15-state maximal-length sequence (0000 is a dead state).
  function automatic word_t lfsr_next(input word_t q);
    return {q[2:0], q[3] ^ q[2]};
  endfunction

endpackage

// File: rtl/lfsr_checker.sv
// Synchronises to a received 4-bit LFSR sequence, then counts mismatching words.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int unsigned LOCK_CNT   = 4,
  parameter int unsigned UNLOCK_CNT = 3,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [3:0]       data_in,
  input  logic             clear_cnt,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_count
);

  localparam int unsigned RUN_W = 4;
  localparam logic [RUN_W-1:0] LOCK_LAST   = RUN_W'(LOCK_CNT - 1);
  localparam logic [RUN_W-1:0] UNLOCK_LAST = RUN_W'(UNLOCK_CNT - 1);

  state_t           state;
  word_t            expected;
  logic [RUN_W-1:0] match_cnt;
  logic [RUN_W-1:0] miss_cnt;
  logic             word_match_c;

  assign word_match_c = (data_in == expected);

  // Lock FSM, flywheel prediction, error pulse and saturating error counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_SEARCH;
      expected  <= LFSR_W'(1);
      match_cnt <= '0;
      miss_cnt  <= '0;
      locked    <= 1'b0;
      err       <= 1'b0;
      err_count <= '0;
    end else begin
      err <= 1'b0;
      // A mismatch counted in the same cycle overrides this below.
      if (clear_cnt) err_count <= '0;

      if (in_valid) begin
        unique case (state)
          ST_SEARCH: begin
            if (data_in != '0) begin
              expected  <= lfsr_next(data_in);
              match_cnt <= '0;
              state     <= ST_VERIFY;
            end
          end

          ST_VERIFY: begin
            if (data_in == '0) begin
              state <= ST_SEARCH;
            end else if (word_match_c) begin
              expected <= lfsr_next(data_in);
              if (match_cnt == LOCK_LAST) begin
                state    <= ST_LOCKED;
                locked   <= 1'b1;
                miss_cnt <= '0;
              end else begin
                match_cnt <= match_cnt + RUN_W'(1);
              end
            end else begin
              match_cnt <= '0;
              expected  <= lfsr_next(data_in);
            end
          end

          ST_LOCKED: begin
            // Flywheel: prediction never resyncs to received data once locked.
            expected <= lfsr_next(expected);
            if (word_match_c) begin
              miss_cnt <= '0;
            end else begin
              err <= 1'b1;
              if (clear_cnt)      err_count <= CNT_W'(1);
              else if (!(&err_count)) err_count <= err_count + CNT_W'(1);
              if (miss_cnt == UNLOCK_LAST) begin
                state    <= ST_SEARCH;
                locked   <= 1'b0;
                miss_cnt <= '0;
              end else begin
                miss_cnt <= miss_cnt + RUN_W'(1);
              end
            end
          end

          default: state <= ST_SEARCH;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lfsr_checker.sv
// Self-checking bench for lfsr_checker: directed scenarios plus randomized traffic
// compared against a table-driven reference model.
module tb_lfsr_checker;

  localparam int unsigned LOCK_CNT   = 4;
  localparam int unsigned UNLOCK_CNT = 3;
  localparam int unsigned CNT_W      = 8;
  localparam int          SAT        = 255;
  localparam int          SEQ_LEN    = 15;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [3:0]       data_in;
  logic             clear_cnt;
  logic             locked;
  logic             err;
  logic [CNT_W-1:0] err_count;

  int checks = 0;
  int errors = 0;

  // Reference model: expected word kept as a position in the published sequence.
  int seq [SEQ_LEN] = '{1, 2, 4, 9, 3, 6, 13, 10, 5, 11, 7, 15, 14, 12, 8};
  int m_mode;       // 0 search, 1 verify, 2 locked
  int m_pos;
  int m_match;
  int m_miss;
  int m_cnt;
  int m_err;

  lfsr_checker #(
    .LOCK_CNT  (LOCK_CNT),
    .UNLOCK_CNT(UNLOCK_CNT),
    .CNT_W     (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .data_in  (data_in),
    .clear_cnt(clear_cnt),
    .locked   (locked),
    .err      (err),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  function automatic int pos_of(input int w);
    for (int i = 0; i < SEQ_LEN; i++) if (seq[i] == w) return i;
    return 0;
  endfunction

  function automatic int exp_word();
    return seq[m_pos];
  endfunction

  task automatic model_step(input bit v, input int d, input bit c, input bit r);
    bit counted;
    counted = 1'b0;
    m_err   = 0;
    if (r) begin
      m_mode = 0; m_pos = 0; m_match = 0; m_miss = 0; m_cnt = 0;
      return;
    end
    if (v) begin
      case (m_mode)
        0: if (d != 0) begin
          m_pos = (pos_of(d) + 1) % SEQ_LEN; m_match = 0; m_mode = 1;
        end
        1: begin
          if (d == 0) m_mode = 0;
          else if (d == seq[m_pos]) begin
            m_match++;
            m_pos = (pos_of(d) + 1) % SEQ_LEN;
            if (m_match == LOCK_CNT) begin m_mode = 2; m_miss = 0; end
          end else begin
            m_match = 0;
            m_pos = (pos_of(d) + 1) % SEQ_LEN;
          end
        end
        default: begin
          if (d == seq[m_pos]) m_miss = 0;
          else begin
            counted = 1'b1;
            m_err   = 1;
            m_cnt   = c ? 1 : ((m_cnt < SAT) ? m_cnt + 1 : SAT);
            m_miss++;
            if (m_miss == UNLOCK_CNT) begin m_mode = 0; m_miss = 0; end
          end
          m_pos = (m_pos + 1) % SEQ_LEN;
        end
      endcase
    end
    if (c && !counted) m_cnt = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, advance the model, compare all outputs.
  task automatic step(input bit v, input int d, input bit c, input bit r);
    rst = r; in_valid = v; data_in = 4'(d); clear_cnt = c;
    @(posedge clk);
    #1;
    model_step(v, d, c, r);
    chk("locked",    32'(locked),    32'(m_mode == 2));
    chk("err",       32'(err),       32'(m_err));
    chk("err_count", 32'(err_count), 32'(m_cnt));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, int'($urandom_range(0, 15)), 1'b0, 1'b0);
  endtask

  initial begin
    int errs_seen;
    int w;
    int src;
    rst = 1'b1; in_valid = 1'b0; data_in = 4'h0; clear_cnt = 1'b0;

    // Reset state
    step(1'b0, 0, 1'b0, 1'b1);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_count",  32'(err_count), 32'd0);

    // Acquire lock on 0001,0010,0100,1001,0011
    step(1'b1, 4'b0001, 1'b0, 1'b0);
    step(1'b1, 4'b0010, 1'b0, 1'b0);
    step(1'b1, 4'b0100, 1'b0, 1'b0);
    step(1'b1, 4'b1001, 1'b0, 1'b0);
    chk("not_yet_locked", 32'(locked), 32'd0);
    step(1'b1, 4'b0011, 1'b0, 1'b0);
    chk("lock_reached", 32'(locked), 32'd1);
    chk("lock_no_err",  32'(err_count), 32'd0);

    // Expecting 0110: feed 0000 (error) then 1101 (correct via flywheel)
    step(1'b1, 4'b0000, 1'b0, 1'b0);
    chk("zero_err_pulse", 32'(err), 32'd1);
    step(1'b1, 4'b1101, 1'b0, 1'b0);
    chk("err_one_cycle", 32'(err), 32'd0);
    chk("count_one", 32'(err_count), 32'd1);
    chk("still_locked", 32'(locked), 32'd1);
    idle(2);

    // Three consecutive wrong words -> unlock; then 0000 ignored in SEARCH
    for (int i = 0; i < 3; i++) step(1'b1, exp_word() ^ 5, 1'b0, 1'b0);
    chk("unlock_count", 32'(err_count), 32'd4);
    chk("unlocked", 32'(locked), 32'd0);
    step(1'b1, 0, 1'b0, 1'b0);
    chk("search_zero_ign", 32'(err), 32'd0);

    // Relock, then 300 alternating wrong/correct words to saturate
    w = 6;
    for (int i = 0; i < 5; i++) begin step(1'b1, seq[w], 1'b0, 1'b0); w = (w + 1) % SEQ_LEN; end
    chk("relock", 32'(locked), 32'd1);
    for (int i = 0; i < 300; i++) begin
      step(1'b1, exp_word() ^ 3, 1'b0, 1'b0);
      step(1'b1, exp_word(), 1'b0, 1'b0);
    end
    chk("saturated", 32'(err_count), 32'd255);
    chk("sat_locked", 32'(locked), 32'd1);
    step(1'b1, exp_word() ^ 9, 1'b1, 1'b0);
    chk("clear_with_miss", 32'(err_count), 32'd1);
    step(1'b1, exp_word(), 1'b1, 1'b0);
    chk("clear_alone", 32'(err_count), 32'd0);

    // Lock across in_valid gaps, then reset while locked and relock
    step(1'b0, 0, 1'b0, 1'b1);
    w = 3;
    for (int i = 0; i < 5; i++) begin
      idle(int'($urandom_range(1, 5)));
      step(1'b1, seq[w], 1'b0, 1'b0);
      w = (w + 1) % SEQ_LEN;
    end
    chk("gap_lock", 32'(locked), 32'd1);
    step(1'b1, exp_word() ^ 1, 1'b0, 1'b0);
    step(1'b1, exp_word(), 1'b0, 1'b1);
    chk("rst_mid_lock", 32'(locked), 32'd0);
    chk("rst_mid_count", 32'(err_count), 32'd0);
    w = 9;
    for (int i = 0; i < 4; i++) begin step(1'b1, seq[w], 1'b0, 1'b0); w = (w + 1) % SEQ_LEN; end
    chk("relock_needs_5", 32'(locked), 32'd0);
    step(1'b1, seq[w], 1'b0, 1'b0);
    chk("relock_5", 32'(locked), 32'd1);

    // Randomized traffic: mostly-correct stream with gaps, glitches, clears and resets
    src = int'($urandom_range(0, SEQ_LEN - 1));
    errs_seen = 0;
    for (int i = 0; i < 3000; i++) begin
      bit v, c, r;
      int d;
      v = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 49) == 0);
      r = ($urandom_range(0, 299) == 0);
      d = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 15)) : seq[src];
      if ($urandom_range(0, 99) == 0) src = int'($urandom_range(0, SEQ_LEN - 1));
      if (v) src = (src + 1) % SEQ_LEN;
      step(v, d, c, r);
      errs_seen += m_err;
    end
    chk("random_saw_errors", 32'(errs_seen > 0), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
